// File: rtl/jelly_axi4_pkg.sv
// jelly_axi4_pkg: shared AXI4 burst/size encodings and default attribute constants
package jelly_axi4_pkg;
  typedef enum logic [1:0] {BURST_FIXED = 2'b00, BURST_INCR = 2'b01, BURST_WRAP = 2'b10} axi4_burst_t;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0001;
  localparam logic [2:0] PROT_DEFAULT = 3'b000;
  localparam logic [3:0] QOS_DEFAULT = 4'b0000;
  localparam logic [3:0] REGION_DEFAULT = 4'b0000;
endpackage

// File: rtl/jelly_axi4_read_order_fifo.sv
// jelly_axi4_read_order_fifo: first-word fall-through FIFO tracking which requester owns each burst
module jelly_axi4_read_order_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic             aresetn,
  input  logic             aclk,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/jelly_axi4_read_scheduler.sv
// jelly_axi4_read_scheduler: round-robin sharing of one AXI4 read master among several requesters,
// with read beats routed back in burst order through an order FIFO.
module jelly_axi4_read_scheduler
  import jelly_axi4_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PORT_SEL_WIDTH = 4,
  parameter int AXI4_ID_WIDTH = 6,
  parameter int AXI4_ADDR_WIDTH = 32,
  parameter int AXI4_DATA_SIZE = 4,
  parameter int AXI4_DATA_WIDTH = 8 << AXI4_DATA_SIZE,
  parameter int AXI4_LEN_WIDTH = 8,
  parameter logic [AXI4_ID_WIDTH-1:0] AXI4_ARID = '0,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                 aresetn,
  input  logic                                 aclk,
  input  logic [NUM_PORTS*AXI4_ADDR_WIDTH-1:0] s_araddr,
  input  logic [NUM_PORTS*AXI4_LEN_WIDTH-1:0]  s_arlen,
  input  logic [NUM_PORTS-1:0]                 s_arvalid,
  output logic [NUM_PORTS-1:0]                 s_arready,
  output logic [AXI4_DATA_WIDTH-1:0]           s_rdata,
  output logic [1:0]                           s_rresp,
  output logic                                 s_rlast,
  output logic [NUM_PORTS-1:0]                 s_rvalid,
  input  logic [NUM_PORTS-1:0]                 s_rready,
  output logic [AXI4_ID_WIDTH-1:0]             m_axi4_arid,
  output logic [AXI4_ADDR_WIDTH-1:0]           m_axi4_araddr,
  output logic [AXI4_LEN_WIDTH-1:0]            m_axi4_arlen,
  output logic [2:0]                           m_axi4_arsize,
  output logic [1:0]                           m_axi4_arburst,
  output logic                                 m_axi4_arlock,
  output logic [3:0]                           m_axi4_arcache,
  output logic [2:0]                           m_axi4_arprot,
  output logic [3:0]                           m_axi4_arqos,
  output logic [3:0]                           m_axi4_arregion,
  output logic                                 m_axi4_arvalid,
  input  logic                                 m_axi4_arready,
  input  logic [AXI4_ID_WIDTH-1:0]             m_axi4_rid,
  input  logic [AXI4_DATA_WIDTH-1:0]           m_axi4_rdata,
  input  logic [1:0]                           m_axi4_rresp,
  input  logic                                 m_axi4_rlast,
  input  logic                                 m_axi4_rvalid,
  output logic                                 m_axi4_rready
);
  logic [PORT_SEL_WIDTH-1:0] rr_ptr, grant_sel, idx, head;
  logic [AXI4_ADDR_WIDTH-1:0] sel_addr;
  logic [AXI4_LEN_WIDTH-1:0] sel_len;
  logic [NUM_PORTS-1:0] head_mask;
  logic grant_valid, load_en, fifo_full, fifo_empty, push, pop, unused_rid;
  assign m_axi4_arid = AXI4_ARID;
  assign m_axi4_arsize = 3'(AXI4_DATA_SIZE);
  assign m_axi4_arburst = BURST_INCR;
  assign m_axi4_arlock = 1'b0;
  assign m_axi4_arcache = CACHE_DEFAULT;
  assign m_axi4_arprot = PROT_DEFAULT;
  assign m_axi4_arqos = QOS_DEFAULT;
  assign m_axi4_arregion = REGION_DEFAULT;
  assign unused_rid = ^m_axi4_rid;
  assign load_en = (!m_axi4_arvalid || m_axi4_arready) && !fifo_full;
  // Scan from the highest offset down so the port nearest rr_ptr wins last.
  always_comb begin
    grant_valid = 1'b0;
    grant_sel = '0;
    idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      idx = PORT_SEL_WIDTH'((int'(rr_ptr) + i) % NUM_PORTS);
      if (|(s_arvalid & (NUM_PORTS'(1) << idx))) begin
        grant_valid = 1'b1;
        grant_sel = idx;
      end
    end
  end
  always_comb begin
    sel_addr = '0;
    sel_len = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_sel == PORT_SEL_WIDTH'(i)) begin
        sel_addr = s_araddr[i*AXI4_ADDR_WIDTH +: AXI4_ADDR_WIDTH];
        sel_len = s_arlen[i*AXI4_LEN_WIDTH +: AXI4_LEN_WIDTH];
      end
    end
  end
  assign push = aresetn && load_en && grant_valid;
  assign s_arready = push ? NUM_PORTS'(1) << grant_sel : '0;
  // A beat already accepted while the FIFO is full must not be presented again.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_axi4_arvalid <= 1'b0;
      m_axi4_araddr <= '0;
      m_axi4_arlen <= '0;
      rr_ptr <= '0;
    end else if (load_en) begin
      m_axi4_arvalid <= grant_valid;
      if (grant_valid) begin
        m_axi4_araddr <= sel_addr;
        m_axi4_arlen <= sel_len;
        rr_ptr <= grant_sel == PORT_SEL_WIDTH'(NUM_PORTS - 1) ? '0 : grant_sel + 1'b1;
      end
    end else if (m_axi4_arready) begin
      m_axi4_arvalid <= 1'b0;
    end
  end
  jelly_axi4_read_order_fifo #(
    .WIDTH(PORT_SEL_WIDTH),
    .DEPTH(MAX_OUTSTANDING)
  ) u_order_fifo (
    .aresetn(aresetn),
    .aclk(aclk),
    .push(push),
    .din(grant_sel),
    .pop(pop),
    .dout(head),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  assign head_mask = NUM_PORTS'(1) << head;
  assign m_axi4_rready = !fifo_empty && |(s_rready & head_mask);
  assign s_rvalid = (m_axi4_rvalid && !fifo_empty) ? head_mask : '0;
  assign pop = m_axi4_rvalid && m_axi4_rready && m_axi4_rlast;
  assign s_rdata = m_axi4_rdata;
  assign s_rresp = m_axi4_rresp;
  assign s_rlast = m_axi4_rlast;
endmodule

// File: tb/tb_jelly_axi4_read_scheduler.sv
// tb_jelly_axi4_read_scheduler: directed scenario bench for the read scheduler
module tb_jelly_axi4_read_scheduler;
  localparam int NP = 4;
  localparam int AW = 32;
  localparam int LW = 8;
  localparam int DW = 128;
  localparam int IW = 6;
  logic aresetn, aclk;
  logic [NP*AW-1:0] s_araddr;
  logic [NP*LW-1:0] s_arlen;
  logic [NP-1:0] s_arvalid, s_arready, s_rvalid, s_rready;
  logic [DW-1:0] s_rdata, m_axi4_rdata;
  logic [1:0] s_rresp, m_axi4_rresp, m_axi4_arburst;
  logic s_rlast, m_axi4_arvalid, m_axi4_arready, m_axi4_arlock, m_axi4_rlast, m_axi4_rvalid, m_axi4_rready;
  logic [IW-1:0] m_axi4_arid, m_axi4_rid;
  logic [AW-1:0] m_axi4_araddr;
  logic [LW-1:0] m_axi4_arlen;
  logic [2:0] m_axi4_arsize, m_axi4_arprot;
  logic [3:0] m_axi4_arcache, m_axi4_arqos, m_axi4_arregion;
  int checks = 0;
  int failures = 0;
  logic [AW-1:0] exp_addr [NP];
  logic [LW-1:0] exp_len [NP];

  jelly_axi4_read_scheduler dut (
    .aresetn(aresetn), .aclk(aclk),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_axi4_arid(m_axi4_arid), .m_axi4_araddr(m_axi4_araddr), .m_axi4_arlen(m_axi4_arlen),
    .m_axi4_arsize(m_axi4_arsize), .m_axi4_arburst(m_axi4_arburst), .m_axi4_arlock(m_axi4_arlock),
    .m_axi4_arcache(m_axi4_arcache), .m_axi4_arprot(m_axi4_arprot), .m_axi4_arqos(m_axi4_arqos),
    .m_axi4_arregion(m_axi4_arregion), .m_axi4_arvalid(m_axi4_arvalid), .m_axi4_arready(m_axi4_arready),
    .m_axi4_rid(m_axi4_rid), .m_axi4_rdata(m_axi4_rdata), .m_axi4_rresp(m_axi4_rresp),
    .m_axi4_rlast(m_axi4_rlast), .m_axi4_rvalid(m_axi4_rvalid), .m_axi4_rready(m_axi4_rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic step;
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset;
    aresetn = 1'b0;
    s_arvalid = '0;
    s_rready = '0;
    m_axi4_arready = 1'b0;
    m_axi4_rvalid = 1'b0;
    m_axi4_rlast = 1'b0;
    m_axi4_rdata = '0;
    m_axi4_rresp = 2'b00;
    repeat (2) step();
    aresetn = 1'b1;
  endtask

  task automatic test_reset;
    aresetn = 1'b0;
    s_arvalid = 4'hf;
    s_rready = 4'hf;
    m_axi4_arready = 1'b1;
    m_axi4_rvalid = 1'b0;
    repeat (3) step();
    checks++; if (m_axi4_arvalid !== 1'b0) begin failures++; $display("FAIL reset_arvalid got %b exp 0", m_axi4_arvalid); end
    checks++; if (m_axi4_araddr !== '0) begin failures++; $display("FAIL reset_araddr got %h exp 0", m_axi4_araddr); end
    checks++; if (s_arready !== 4'b0000) begin failures++; $display("FAIL reset_s_arready got %b exp 0000", s_arready); end
    checks++; if (m_axi4_rready !== 1'b0) begin failures++; $display("FAIL reset_rready got %b exp 0", m_axi4_rready); end
    checks++; if (m_axi4_arburst !== 2'b01 || m_axi4_arcache !== 4'b0001 || m_axi4_arsize !== 3'd4) begin failures++; $display("FAIL reset_ar_consts got burst=%b cache=%b size=%0d exp 01/0001/4", m_axi4_arburst, m_axi4_arcache, m_axi4_arsize); end
    aresetn = 1'b1;
    #1;
    checks++; if (s_arready !== 4'b0001) begin failures++; $display("FAIL release_grant got %b exp 0001", s_arready); end
    checks++; if (m_axi4_arvalid !== 1'b0) begin failures++; $display("FAIL release_arvalid got %b exp 0", m_axi4_arvalid); end
    step();
    checks++; if (m_axi4_arvalid !== 1'b1 || m_axi4_araddr !== exp_addr[0] || m_axi4_arlen !== exp_len[0]) begin failures++; $display("FAIL first_ar got v=%b a=%h l=%0d exp v=1 a=%h l=%0d", m_axi4_arvalid, m_axi4_araddr, m_axi4_arlen, exp_addr[0], exp_len[0]); end
  endtask

  task automatic test_fairness;
    do_reset();
    s_arvalid = 4'hf;
    m_axi4_arready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++; if (m_axi4_arvalid !== 1'b1 || m_axi4_araddr !== exp_addr[k%4] || m_axi4_arlen !== exp_len[k%4]) begin failures++; $display("FAIL fair_ar%0d got a=%h l=%0d exp a=%h l=%0d", k, m_axi4_araddr, m_axi4_arlen, exp_addr[k%4], exp_len[k%4]); end
      checks++; if (s_arready !== (k < 7 ? 4'(1 << ((k + 1) % 4)) : 4'b0000)) begin failures++; $display("FAIL fair_grant%0d got %b", k, s_arready); end
    end
    s_arvalid = '0;
  endtask

  task automatic test_routing;
    do_reset();
    m_axi4_arready = 1'b1;
    s_arvalid = 4'b0010;
    #1;
    checks++; if (s_arready !== 4'b0010) begin failures++; $display("FAIL route_grant1 got %b exp 0010", s_arready); end
    step();
    checks++; if (m_axi4_araddr !== exp_addr[1] || m_axi4_arlen !== 8'd3) begin failures++; $display("FAIL route_ar1 got a=%h l=%0d exp a=%h l=3", m_axi4_araddr, m_axi4_arlen, exp_addr[1]); end
    s_arvalid = 4'b1000;
    #1;
    checks++; if (s_arready !== 4'b1000) begin failures++; $display("FAIL route_grant3 got %b exp 1000", s_arready); end
    step();
    checks++; if (m_axi4_araddr !== exp_addr[3] || m_axi4_arlen !== 8'd0) begin failures++; $display("FAIL route_ar3 got a=%h l=%0d exp a=%h l=0", m_axi4_araddr, m_axi4_arlen, exp_addr[3]); end
    s_arvalid = '0;
    step();
    checks++; if (m_axi4_arvalid !== 1'b0) begin failures++; $display("FAIL route_ar_idle got %b exp 0", m_axi4_arvalid); end
    s_rready = 4'hf;
    for (int b = 0; b < 5; b++) begin
      m_axi4_rvalid = 1'b1;
      m_axi4_rdata = DW'(b + 100);
      m_axi4_rresp = 2'(b);
      m_axi4_rlast = (b == 3) || (b == 4);
      #1;
      checks++; if (s_rvalid !== (b < 4 ? 4'b0010 : 4'b1000) || s_rdata !== DW'(b + 100) || s_rresp !== 2'(b) || m_axi4_rready !== 1'b1) begin failures++; $display("FAIL route_beat%0d got rv=%b d=%0d rr=%b", b, s_rvalid, s_rdata, m_axi4_rready); end
      step();
    end
    m_axi4_rvalid = 1'b1;
    m_axi4_rlast = 1'b1;
    #1;
    checks++; if (s_rvalid !== 4'b0000 || m_axi4_rready !== 1'b0) begin failures++; $display("FAIL route_empty got rv=%b rr=%b exp 0000/0", s_rvalid, m_axi4_rready); end
    m_axi4_rvalid = 1'b0;
  endtask

  task automatic test_full;
    do_reset();
    m_axi4_arready = 1'b1;
    s_rready = 4'hf;
    s_arvalid = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++; if (s_arready !== 4'b0001) begin failures++; $display("FAIL full_fill%0d got %b exp 0001", k, s_arready); end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      checks++; if (s_arready !== 4'b0000) begin failures++; $display("FAIL full_block%0d got %b exp 0000", k, s_arready); end
      step();
    end
    m_axi4_rvalid = 1'b1;
    m_axi4_rlast = 1'b1;
    #1;
    checks++; if (s_arready !== 4'b0000 || m_axi4_rready !== 1'b1 || s_rvalid !== 4'b0001) begin failures++; $display("FAIL full_pop got ar=%b rr=%b rv=%b", s_arready, m_axi4_rready, s_rvalid); end
    step();
    m_axi4_rvalid = 1'b0;
    #1;
    checks++; if (s_arready !== 4'b0001) begin failures++; $display("FAIL full_regrant got %b exp 0001", s_arready); end
    step();
    checks++; if (s_arready !== 4'b0000) begin failures++; $display("FAIL full_one_grant got %b exp 0000", s_arready); end
    s_arvalid = '0;
  endtask

  task automatic test_backpressure;
    do_reset();
    m_axi4_arready = 1'b1;
    s_arvalid = 4'b0100;
    step();
    s_arvalid = 4'b0001;
    step();
    s_arvalid = '0;
    m_axi4_rvalid = 1'b1;
    m_axi4_rlast = 1'b1;
    s_rready = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (m_axi4_rready !== 1'b0 || s_rvalid !== 4'b0100) begin failures++; $display("FAIL bp_hold%0d got rr=%b rv=%b exp 0/0100", k, m_axi4_rready, s_rvalid); end
      step();
    end
    s_rready = 4'b0100;
    #1;
    checks++; if (m_axi4_rready !== 1'b1) begin failures++; $display("FAIL bp_release got %b exp 1", m_axi4_rready); end
    step();
    checks++; if (s_rvalid !== 4'b0001) begin failures++; $display("FAIL bp_order got %b exp 0001", s_rvalid); end
    m_axi4_rvalid = 1'b0;
    do_reset();
    s_arvalid = 4'b0010;
    step();
    s_arvalid = 4'hf;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (s_arready !== 4'b0000 || m_axi4_arvalid !== 1'b1 || m_axi4_araddr !== exp_addr[1] || m_axi4_arlen !== exp_len[1]) begin failures++; $display("FAIL ar_stall%0d got ar=%b v=%b a=%h", k, s_arready, m_axi4_arvalid, m_axi4_araddr); end
      step();
    end
    m_axi4_arready = 1'b1;
    #1;
    checks++; if (s_arready !== 4'b0100) begin failures++; $display("FAIL ar_resume got %b exp 0100", s_arready); end
    step();
    checks++; if (m_axi4_araddr !== exp_addr[2]) begin failures++; $display("FAIL ar_next got %h exp %h", m_axi4_araddr, exp_addr[2]); end
    s_arvalid = '0;
  endtask

  initial begin
    exp_len[0] = 8'd2;
    exp_len[1] = 8'd3;
    exp_len[2] = 8'd1;
    exp_len[3] = 8'd0;
    for (int i = 0; i < NP; i++) begin
      exp_addr[i] = 32'h1000_0000 + 32'(i) * 32'h100;
      s_araddr[i*AW +: AW] = exp_addr[i];
      s_arlen[i*LW +: LW] = exp_len[i];
    end
    m_axi4_rid = '0;
    m_axi4_rdata = '0;
    m_axi4_rresp = 2'b00;
    m_axi4_rlast = 1'b0;
    test_reset();
    test_fairness();
    test_routing();
    test_full();
    test_backpressure();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
